coin_detect: RTL and testbench

Front-end coin detector for the vending-machine datapath. It synchronises and debounces the two raw coin-chute sensors (50 cent, 1 Euro). For each inserted coin it emits exactly one single-cycle coin code on the 2-bit coin bus that feeds the credit-accumulation FSM. It also flags simultaneous or overlapping sensor activity as a jam, and withholds the coin code in that case.

---
 rtl/coin_detect.sv | 135 +++++++++++++
 tb/tb_coin_detect.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/coin_detect.sv
// coin_detect: synchronises and debounces the 50c / 1-Euro coin-chute
// sensors and emits one single-cycle coin code per inserted coin.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   s50   in   raw 50-cent sensor (async, bouncy)
//   s100  in   raw 1-Euro sensor (async, bouncy)
//   x     out  coin code: 01 = 50c, 10 = 1 Euro, 00 = none (registered)
//   err   out  one-cycle jam pulse (registered)
module coin_detect #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s50,
   input  logic       s100,
   output logic [1:0] x,
   output logic       err
);

   localparam logic [1:0] ST_WAIT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_C50  = 2'd2;
   localparam logic [1:0] ST_C100 = 2'd3;

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   // Channel index 0 = 50c, 1 = 1 Euro.
   logic [1:0]      s50_sync_q;
   logic [1:0]      s100_sync_q;
   logic [1:0]      sync_s;
   logic [1:0]      d_q, d_d;
   logic [1:0][7:0] cnt_q, cnt_d;
   logic [1:0]      state_q, state_d;
   logic [1:0]      x_q, x_d;
   logic            err_q, err_d;

   // Synchroniser and debounced levels reset high so a coin already
   // in the chute at reset must be released before anything counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s50_sync_q  <= 2'b11;
         s100_sync_q <= 2'b11;
      end else begin
         s50_sync_q  <= {s50_sync_q[0], s50};
         s100_sync_q <= {s100_sync_q[0], s100};
      end
   end

   assign sync_s = {s100_sync_q[1], s50_sync_q[1]};

   always_comb begin
      d_d   = d_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync_s[i] == d_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            d_d[i]   = sync_s[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q   <= 2'b11;
         cnt_q <= '0;
      end else begin
         d_q   <= d_d;
         cnt_q <= cnt_d;
      end
   end

   // Coin codes only leave IDLE; any second channel seen while a coin
   // is in progress is a jam and parks the FSM until both release.
   always_comb begin
      state_d = state_q;
      x_d     = 2'b00;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (d_q[0] && d_q[1]) begin
               state_d = ST_WAIT;
               err_d   = 1'b1;
            end else if (d_q[0]) begin
               state_d = ST_C50;
               x_d     = 2'b01;
            end else if (d_q[1]) begin
               state_d = ST_C100;
               x_d     = 2'b10;
            end
         end
         ST_C50: begin
            if (d_q[1]) begin
               state_d = ST_WAIT;
               err_d   = 1'b1;
            end else if (!d_q[0]) begin
               state_d = ST_IDLE;
            end
         end
         ST_C100: begin
            if (d_q[0]) begin
               state_d = ST_WAIT;
               err_d   = 1'b1;
            end else if (!d_q[1]) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!d_q[0] && !d_q[1]) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_WAIT;
         x_q     <= 2'b00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         err_q   <= err_d;
      end
   end

   assign x   = x_q;
   assign err = err_q;

endmodule

// File: tb/tb_coin_detect.sv
// tb_coin_detect: table-driven and hand-sequenced checks of coin_detect
// with a scoreboard queue of expected {x, err} per clock.
module tb_coin_detect;

   localparam logic [1:0] EXP_WAIT = 2'd0;
   localparam logic [1:0] EXP_IDLE = 2'd1;

   logic       clk = 1'b0;
   logic       rst;
   logic       s50;
   logic       s100;
   logic [1:0] x;
   logic       err;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [1:0] x;
      logic       err;
   } exp_t;

   typedef struct {
      string       name;
      logic [63:0] p50;
      logic [63:0] p100;
      logic [1:0]  xc;
      int          x1;
      int          x2;
      int          e1;
   } vec_t;

   exp_t sbq[$];
   vec_t tbl[7];

   coin_detect #(.DEBOUNCE_CYCLES(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .s50  (s50),
      .s100 (s100),
      .x    (x),
      .err  (err)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] rng(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int k = lo; k <= hi; k++) m[k] = 1'b1;
      return m;
   endfunction

   // Drive one cycle's inputs at a falling edge, queue what must be seen
   // one cycle later, then pop and compare at the next falling edge.
   task automatic cyc(input logic r, input logic a, input logic b,
                      input logic [1:0] ex, input logic ee,
                      input string tag);
      exp_t e;
      rst  = r;
      s50  = a;
      s100 = b;
      e.x   = ex;
      e.err = ee;
      sbq.push_back(e);
      @(negedge clk);
      e = sbq.pop_front();
      nvec++;
      if (x !== e.x || err !== e.err) begin
         nerr++;
         $display("FAIL %s t=%0t: x=%b err=%b, want x=%b err=%b",
                  tag, $time, x, err, e.x, e.err);
      end
   endtask

   task automatic chk_state(input logic [1:0] want, input string tag);
      nvec++;
      if (dut.state_q !== want) begin
         nerr++;
         $display("FAIL %s: state=%0d, want %0d", tag, dut.state_q, want);
      end
   endtask

   initial begin
      logic [1:0] ex;
      logic       ee;

      tbl[0] = '{"clean50",  rng(2, 13), '0, 2'b01, 9, -1, -1};
      tbl[1] = '{"clean100", '0, rng(2, 13), 2'b10, 9, -1, -1};
      tbl[2] = '{"bounce",   rng(2, 2) | rng(4, 5) | rng(7, 16), '0,
                 2'b01, 14, -1, -1};
      tbl[3] = '{"pulse3",   rng(2, 4), '0, 2'b01, -1, -1, -1};
      tbl[4] = '{"dropout",  rng(2, 13) | rng(17, 28), '0,
                 2'b01, 9, -1, -1};
      tbl[5] = '{"jam",      rng(2, 11), rng(2, 11), 2'b00, -1, -1, 9};
      tbl[6] = '{"overlap",  rng(2, 16) | rng(32, 39), rng(7, 16),
                 2'b01, 9, 39, 14};

      rst  = 1'b1;
      s50  = 1'b0;
      s100 = 1'b0;
      @(negedge clk);

      repeat (3) cyc(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "rst_hold");
      for (int j = 1; j <= 7; j++) begin
         cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "rst_release");
         if (j == 6) chk_state(EXP_WAIT, "wait_edge6");
      end
      chk_state(EXP_IDLE, "idle_edge7");

      for (int t = 0; t < 7; t++) begin
         for (int j = 0; j < 64; j++) begin
            ex = (j + 1 == tbl[t].x1 || j + 1 == tbl[t].x2) ?
                 tbl[t].xc : 2'b00;
            ee = (j + 1 == tbl[t].e1);
            cyc(1'b0, tbl[t].p50[j], tbl[t].p100[j], ex, ee, tbl[t].name);
         end
      end

      for (int j = 0; j <= 6; j++)
         cyc(1'b0, 1'b1, 1'b0, (j == 6) ? 2'b01 : 2'b00, 1'b0,
             "held_pre");
      rst = 1'b1;
      #1;
      nvec++;
      if (x !== 2'b00 || err !== 1'b0) begin
         nerr++;
         $display("FAIL async_clear: x=%b err=%b, want x=00 err=0", x, err);
      end
      repeat (2) cyc(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, "held_rst");
      repeat (20) cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, "held_post");
      repeat (12) cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "held_release");
      for (int j = 0; j < 8; j++)
         cyc(1'b0, 1'b1, 1'b0, (j == 6) ? 2'b01 : 2'b00, 1'b0,
             "fresh_press");
      repeat (12) cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "fresh_release");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
